// File: rtl/itof_pipe_if.sv
// itof_pipe_if: operand/result handshake bundle for the itof_pipe converter.
// The slave modport is the converter's view; the master modport is the view of
// whatever feeds operands and consumes results.
interface itof_pipe_if #(
  parameter int WIDTH = 32
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] x;
  logic                    out_valid;
  logic                    out_ready;
  logic        [31:0]      y;

  modport slave (
    input  in_valid,
    input  x,
    input  out_ready,
    output in_ready,
    output out_valid,
    output y
  );

  modport master (
    output in_valid,
    output x,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  y
  );
endinterface

// File: rtl/itof_pipe.sv
// itof_pipe: 3-stage signed 32-bit integer to IEEE-754 single converter.
//   S1 (_p0): sign / magnitude
//   S2 (_p1): leading-zero count, normalize, biased exponent
//   S3 (_p2): round and pack, drives y / out_valid
// All stages advance together when the output is empty or being consumed, so
// in_ready is a pure function of out_valid and out_ready.
// Optional build macro ITOF_TRUNC_EN: round toward zero instead of
// round-to-nearest-even (no increment, no exponent carry).
module itof_pipe #(
  parameter int STAGES = 3,
  parameter int WIDTH  = 32
) (
  input  logic        clk,
  input  logic        rst,
  itof_pipe_if.slave  bus
);

  localparam logic [7:0] EXP_TOP = 8'd158;  // bias 127 + 31

  if (STAGES != 3) begin : g_bad_stages
    $error("itof_pipe: STAGES must be 3");
  end
  if (WIDTH != 32) begin : g_bad_width
    $error("itof_pipe: WIDTH must be 32");
  end

  // Magnitude of a two's-complement value; 32'h80000000 maps onto itself,
  // which is the correct unsigned magnitude 2^31.
  function automatic logic [31:0] f_abs(input logic signed [31:0] v);
    logic [31:0] u;
    u = v;
    return v[31] ? (~u + 32'd1) : u;
  endfunction

  // Leading-zero count; an all-zero input reports 0 and is flagged separately.
  function automatic logic [4:0] f_lzc(input logic [31:0] v);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) n = 5'(31 - i);
    end
    return n;
  endfunction

  // Round the normalized magnitude (hidden bit stripped) to 23 mantissa bits
  // and return {exponent, mantissa}. A mantissa carry ripples into the
  // exponent naturally; the exponent never exceeds 158 so no overflow.
  function automatic logic [30:0] f_round(input logic [7:0] e, input logic [30:0] nrm);
    logic [30:0] em;
`ifdef ITOF_TRUNC_EN
    em = {e, nrm[30:8]};
`else
    logic g;
    logic r;
    logic st;
    em = {e, nrm[30:8]};
    g  = nrm[7];
    r  = nrm[6];
    st = |nrm[5:0];
    if (g && (r || st || nrm[8])) em = em + 31'd1;
`endif
    return em;
  endfunction

  logic        w_adv;

  logic        r_vld_p0;
  logic        r_vld_p1;
  logic        r_vld_p2;

  logic        r_s_p0;
  logic [31:0] r_mag_p0;

  logic        r_s_p1;
  logic [7:0]  r_e_p1;
  logic [31:0] r_norm_p1;
  logic        r_zero_p1;

  logic [31:0] r_y_p2;

  logic [31:0] w_mag;
  logic [4:0]  w_lz;
  logic [31:0] w_norm;
  logic [7:0]  w_e;
  logic [30:0] w_em;
  logic [31:0] w_y;

  assign w_adv         = !r_vld_p2 || bus.out_ready;
  assign bus.in_ready  = w_adv;
  assign bus.out_valid = r_vld_p2;
  assign bus.y         = r_y_p2;

  assign w_mag  = f_abs(bus.x);
  assign w_lz   = f_lzc(r_mag_p0);
  assign w_norm = r_mag_p0 << w_lz;
  assign w_e    = EXP_TOP - {3'b000, w_lz};
  assign w_em   = f_round(r_e_p1, r_norm_p1[30:0]);
  assign w_y    = r_zero_p1 ? 32'h0000_0000 : {r_s_p1, w_em};

  // Valid bits shift in lockstep with the data; bubbles are kept, not squeezed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p0 <= 1'b0;
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
    end else if (w_adv) begin
      r_vld_p0 <= bus.in_valid;
      r_vld_p1 <= r_vld_p0;
      r_vld_p2 <= r_vld_p1;
    end
  end

  // ---- S1: sign and magnitude ----
  always_ff @(posedge clk) begin
    if (w_adv && bus.in_valid) begin
      r_s_p0   <= bus.x[31];
      r_mag_p0 <= w_mag;
    end
  end

  // ---- S2: normalize so the leading one sits in bit 31 ----
  always_ff @(posedge clk) begin
    if (w_adv && r_vld_p0) begin
      r_s_p1    <= r_s_p0;
      r_e_p1    <= w_e;
      r_norm_p1 <= w_norm;
      r_zero_p1 <= (r_mag_p0 == 32'h0000_0000);
    end
  end

  // ---- S3: round and pack; y is cleared by reset and otherwise only loads real results ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_y_p2 <= 32'h0000_0000;
    end else if (w_adv && r_vld_p1) begin
      r_y_p2 <= w_y;
    end
  end

endmodule

// File: doc/itof_pipe.md
Name: itof_pipe

Overview:
- Pipelined signed 32-bit integer to IEEE-754 single-precision converter. It is the reverse direction of the FPU's ftoi unit.
- Serves the FPU's `fcvt.s.w`-class operations. It accepts one operand per cycle behind a valid/ready handshake.
- Fixed 3-stage pipeline with full backpressure. Rounding is round-to-nearest-even by default.

Parameters:
- STAGES, 3, pipeline depth. Fixed at 3; any other value is an elaboration error.
- WIDTH, 32, integer input width. Only 32 is supported.

Ports:
- clk  input  1  system clock. Single clock domain.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand x is valid this cycle.
- in_ready  output  1  converter accepts an operand this cycle.
- x  input  32  two's-complement signed integer operand.
- out_valid  output  1  y holds a valid result.
- out_ready  input  1  consumer accepts y this cycle.
- y  output  32  IEEE-754 single result: sign in [31], exponent in [30:23], mantissa in [22:0].

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: all stage valid bits are 0; out_valid = 0; y = 32'h0. in_ready is combinational and equals 1 out of reset.
- Advance condition: adv = !out_valid || out_ready. All three stages shift together when adv = 1 and hold when adv = 0. in_ready = adv.
- Accept/transfer: an input transfer occurs when in_valid && in_ready. An output transfer occurs when out_valid && out_ready. Both can occur in the same cycle.
- Stage valid bits move with adv. A stage captures in_valid on adv, so bubbles propagate and are not collapsed.
- Latency: exactly 3 cycles from accept to out_valid when out_ready is held at 1. Throughput is 1 result per cycle.
- S1, sign/magnitude: register s = x[31] and mag = |x| as 32-bit unsigned. x = 32'h80000000 gives mag = 32'h80000000, with no overflow.
- S2, normalize:
  - Leading-zero count lz (0..31) of mag.
  - norm = mag << lz, so norm[31] = 1 unless mag = 0.
  - e = 158 - lz, 8 bits.
  - Register s, e, norm and a zero flag.
- S3, round and pack:
  - man = norm[30:8]; G = norm[7]; R = norm[6]; St = |norm[5:0].
  - Round up when G && (R || St || man[0]).
  - If man is all ones and rounds up, man becomes 0 and e becomes e+1. The maximum result exponent is 158, so infinity/overflow cannot occur.
  - Zero input gives y = 32'h00000000. Negative zero is never produced.
  - Magnitudes below 2^24 are exact (G = R = St = 0).
- Hold: while out_valid && !out_ready, y and out_valid stay stable and no register in any stage changes.
- Reset mid-operation: asserting rst at any time clears every valid bit immediately. In-flight operands are discarded. The first result after release comes only from an operand accepted after release.
- Combinational paths: none from x to y. The only combinational path in the block is out_ready to in_ready.

Optional Feature:
- Macro: ITOF_TRUNC_EN.
- Defined: S3 uses round-toward-zero. It discards G/R/St and never increments, matching the truncating semantics of ftoi. The exponent carry path is removed.
- Undefined: round-to-nearest-even as specified above.
- Latency, handshake and ports are identical either way.

Test Plan:
- Basic values, out_ready=1:
  - x=0 -> y=32'h00000000 exactly 3 cycles later.
  - x=1 -> 32'h3F800000.
  - x=-1 (32'hFFFFFFFF) -> 32'hBF800000.
- Extremes:
  - x=32'h80000000 -> 32'hCF000000.
  - x=32'h7FFFFFFF -> 32'h4F000000 (RNE carry into exponent). With ITOF_TRUNC_EN it gives 32'h4EFFFFFF.
- Ties:
  - x=16777217 -> 32'h4B800000 (tie to even, down).
  - x=16777219 -> 32'h4B800002 (tie to even, up).
  - x=-16777219 -> 32'hCB800002.
- Backpressure:
  - Stream x=1..10 with in_valid=1 and out_ready toggling 1,0,0,1,...
  - Required: 10 results, in order, none duplicated or lost.
  - Required: y stable while out_ready=0, and in_ready=0 whenever out_valid && !out_ready.
- Reset mid-flight: accept 3 operands, then pulse rst for 1 cycle between clock edges -> out_valid=0 immediately and y=0. No stale outputs afterwards; next operand x=2 -> 32'h40000000 after 3 cycles.
- Random: 1000 random x with random out_ready. Compare each result bit-exactly against the simulator's int-to-shortreal conversion; require 0 mismatches.
